eighth_root_extractor: RTL and testbench
========================================

Name: eighth_root_extractor

Overview:
- Inverse of the team's pipelined power-of-eight datapath: takes a 61-bit value and returns floor(value^(1/8)) as an 8-bit root, plus an exactness flag.
- Iterative, MSB-first bit-search engine: one squaring per cycle, three cycles per root bit, one request in flight.
- Sits downstream of power-of-eight outputs for round-trip checking and in any path that needs to recover a base from its eighth power.

Parameters:
- IN_W, 61, input operand width; the root width derives from it.
- ROOT_W, 8, root width; must satisfy 8*ROOT_W >= IN_W. Product width PW = 8*ROOT_W = 64.

Ports:
- i_clock  input  1  rising-edge clock
- i_reset_sync  input  1  synchronous, active-high reset
- i_value  input  IN_W  radicand
- i_status  input  1  request strobe; accepted only when o_ready=1
- o_ready  output  1  high iff FSM in IDLE
- o_value  output  ROOT_W  floor eighth root of last accepted radicand
- o_exact  output  1  1 iff o_value^8 == that radicand
- o_status  output  1  one-cycle completion pulse

Behaviour:
- Reset (sampled at a clock edge with i_reset_sync=1): state=IDLE, o_ready=1, o_value=0, o_exact=0, o_status=0, all internal registers=0. Reset wins over every other event, including mid-computation; the in-flight request is discarded with no o_status pulse.
- States: IDLE, SQ2, SQ4, SQ8, DONE.
- IDLE: on an edge with i_status=1, latch x=i_value, root=0, bit index k=ROOT_W-1, eq=(i_value==0); go to SQ2. With i_status=0, stay in IDLE.
- Candidate: c = root | (1<<k).
- SQ2: p <= c*c. Go to SQ4.
- SQ4: p <= p*p. Go to SQ8.
- SQ8: q = p*p, computed at full PW width with no truncation; 255^8 < 2^64.
  - If q <= zero-extended x: root <= c, eq <= (q==x).
  - If k==0: go to DONE. Otherwise k <= k-1 and go to SQ2.
- DONE: o_value <= root, o_exact <= eq, o_status=1 for this single cycle; go to IDLE.
- Latency: request accepted at edge T; o_status is high in the cycle following edge T+3*ROOT_W, i.e. T+24 with defaults. Fixed latency, independent of data.
- o_ready is low from SQ2 through DONE. An i_status pulse while o_ready=0 is ignored: not queued, not flagged. Back-to-back throughput is one request every 3*ROOT_W+1 cycles.
- o_value and o_exact hold their values until the next DONE. They update in the same cycle that o_status is high.
- i_value is sampled only at acceptance; later changes have no effect.
- Boundaries:
  - x=0 gives root 0, exact.
  - x=1 gives root 1, exact.
  - x=2^IN_W-1 gives the maximum root 197 (197^8 <= 2^61-1 < 198^8).
- No arithmetic overflow is possible in any state, given PW=64.

Test Plan:
- Reset, then i_value=6561 (3^8) with a 1-cycle i_status -> o_status pulses exactly 24 cycles after the acceptance edge; o_value=3, o_exact=1; o_ready low throughout the computation.
- i_value=6560 -> o_value=2, o_exact=0. i_value=0 -> o_value=0, o_exact=1. i_value=1 -> o_value=1, o_exact=1.
- i_value=2^61-1 -> o_value=197, o_exact=0. i_value=2562890625 (15^8) -> o_value=15, o_exact=1, matching the round trip of 4-bit input 15 through the power-of-eight block.
- Accept i_value=256 (2^8), then assert i_status with i_value=6561 on cycles 5 and 12 while busy -> exactly one o_status pulse, o_value=2, o_exact=1; o_ready returns high the cycle after DONE; a new request accepted immediately afterwards completes normally.
- Accept i_value=390625 (5^8), assert i_reset_sync at cycle 10 for one cycle -> no o_status pulse; o_value=0, o_exact=0, o_ready=1 on the following cycle; a fresh request for 390625 returns o_value=5, o_exact=1 with nominal latency.
- Randomised sweep: 500 random 61-bit radicands plus n^8 and n^8-1 for n=1..197 -> every result matches a reference floor-root model, and o_exact is set iff the radicand is a perfect eighth power.

Source files
------------

// File: rtl/eighth_root_extractor.sv
// Floor eighth root of an IN_W-bit radicand, found one root bit at a time, MSB first.
// Each candidate bit costs three squarings (c^2, c^4, c^8); one request in flight.
module eighth_root_extractor #(
  parameter int IN_W   = 61,
  parameter int ROOT_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset_sync,
  input  logic [IN_W-1:0]   i_value,
  input  logic              i_status,
  output logic              o_ready,
  output logic [ROOT_W-1:0] o_value,
  output logic              o_exact,
  output logic              o_status
);

  localparam int PW = 8 * ROOT_W;
  localparam int KW = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ2,
    S_SQ4,
    S_SQ8,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     x_q, x_d;
  logic [ROOT_W-1:0]   root_q, root_d;
  logic [KW-1:0]       k_q, k_d;
  logic                eq_q, eq_d;
  logic [4*ROOT_W-1:0] p_q, p_d;
  logic                ready_q, ready_d;
  logic [ROOT_W-1:0]   value_q, value_d;
  logic                exact_q, exact_d;
  logic                status_q, status_d;

  logic [ROOT_W-1:0]   cand;
  logic [2*ROOT_W-1:0] cand_sq;
  logic [PW-1:0]       q8;
  logic [PW-1:0]       x_ext;
  logic                fits;

  always_comb begin
    cand    = root_q | (ROOT_W'(1) << k_q);
    cand_sq = (2*ROOT_W)'(cand) * (2*ROOT_W)'(cand);
    q8      = PW'(p_q) * PW'(p_q);
    x_ext   = PW'(x_q);
    fits    = (q8 <= x_ext);

    state_d  = state_q;
    x_d      = x_q;
    root_d   = root_q;
    k_d      = k_q;
    eq_d     = eq_q;
    p_d      = p_q;
    ready_d  = ready_q;
    value_d  = value_q;
    exact_d  = exact_q;
    status_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_status) begin
          x_d     = i_value;
          root_d  = '0;
          k_d     = KW'(ROOT_W - 1);
          eq_d    = (i_value == '0);
          ready_d = 1'b0;
          state_d = S_SQ2;
        end
      end
      S_SQ2: begin
        p_d     = (4*ROOT_W)'(cand_sq);
        state_d = S_SQ4;
      end
      S_SQ4: begin
        p_d     = p_q * p_q;
        state_d = S_SQ8;
      end
      S_SQ8: begin
        if (fits) begin
          root_d = cand;
          eq_d   = (q8 == x_ext);
        end
        if (k_q == '0) begin
          // Results are loaded on the way into DONE so they appear with the pulse.
          value_d  = fits ? cand : root_q;
          exact_d  = fits ? (q8 == x_ext) : eq_q;
          status_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          k_d     = k_q - KW'(1);
          state_d = S_SQ2;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset_sync) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      root_q   <= '0;
      k_q      <= '0;
      eq_q     <= 1'b0;
      p_q      <= '0;
      ready_q  <= 1'b1;
      value_q  <= '0;
      exact_q  <= 1'b0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      root_q   <= root_d;
      k_q      <= k_d;
      eq_q     <= eq_d;
      p_q      <= p_d;
      ready_q  <= ready_d;
      value_q  <= value_d;
      exact_q  <= exact_d;
      status_q <= status_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_value  = value_q;
  assign o_exact  = exact_q;
  assign o_status = status_q;

endmodule

// File: tb/tb_eighth_root_extractor.sv
// Bench for eighth_root_extractor: directed boundary cases, busy/reset scenarios and a
// randomized sweep checked against a scan-based floor eighth root model.
module tb_eighth_root_extractor;

  localparam int IN_W   = 61;
  localparam int ROOT_W = 8;
  localparam int LAT    = 3 * ROOT_W;

  logic              i_clock;
  logic              i_reset_sync;
  logic [IN_W-1:0]   i_value;
  logic              i_status;
  logic              o_ready;
  logic [ROOT_W-1:0] o_value;
  logic              o_exact;
  logic              o_status;

  int errors;
  int checks;

  eighth_root_extractor #(.IN_W(IN_W), .ROOT_W(ROOT_W)) dut (
    .i_clock      (i_clock),
    .i_reset_sync (i_reset_sync),
    .i_value      (i_value),
    .i_status     (i_status),
    .o_ready      (o_ready),
    .o_value      (o_value),
    .o_exact      (o_exact),
    .o_status     (o_status)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  function automatic longint unsigned pow8(input int unsigned n);
    longint unsigned r = 1;
    for (int i = 0; i < 8; i++) r = r * longint'(n);
    return r;
  endfunction

  function automatic int unsigned ref_root(input longint unsigned x);
    int unsigned r = 0;
    while (r < 255 && pow8(r + 1) <= x) r++;
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_value();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return IN_W'(w) >> $urandom_range(0, IN_W - 1);
  endfunction

  // One complete request: checks latency, busy ready, results and return to idle.
  task automatic do_req(input logic [IN_W-1:0] v, input logic [ROOT_W-1:0] exp_root,
                        input logic exp_exact, input string name);
    int lat;
    bit ready_err;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before got=%b want=1", name, o_ready);
    end
    i_value  = v;
    i_status = 1'b1;
    tick();
    i_status = 1'b0;
    i_value  = rand_value();
    lat = 0;
    ready_err = 0;
    for (int n = 1; n <= LAT + 16; n++) begin
      tick();
      if (o_ready !== 1'b0) ready_err = 1;
      if (o_status === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL %s latency got=%0d want=%0d (0 = timeout)", name, lat, LAT);
    end
    checks++;
    if (ready_err) begin
      errors++;
      $display("FAIL %s ready_busy got=high want=low while computing", name);
    end
    checks++;
    if (o_value !== exp_root) begin
      errors++;
      $display("FAIL %s value x=%0d got=%0d want=%0d", name, v, o_value, exp_root);
    end
    checks++;
    if (o_exact !== exp_exact) begin
      errors++;
      $display("FAIL %s exact x=%0d got=%b want=%b", name, v, o_exact, exp_exact);
    end
    tick();
    checks++;
    if (o_status !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_done status=%b ready=%b want status=0 ready=1", name, o_status, o_ready);
    end
  endtask

  task automatic test_reset();
    i_reset_sync = 1'b1;
    i_status     = 1'b0;
    i_value      = '0;
    tick();
    tick();
    i_reset_sync = 1'b0;
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_value !== '0 || o_exact !== 1'b0 || o_status !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ready=%b value=%0d exact=%b status=%b want 1/0/0/0",
               o_ready, o_value, o_exact, o_status);
    end
  endtask

  task automatic test_known();
    logic [IN_W-1:0]   vals[7];
    logic [ROOT_W-1:0] roots[7];
    logic              exs[7];
    vals  = '{61'd6561, 61'd6560, 61'd0, 61'd1, {IN_W{1'b1}}, 61'd2562890625, 61'd256};
    roots = '{8'd3, 8'd2, 8'd0, 8'd1, 8'd197, 8'd15, 8'd2};
    exs   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) do_req(vals[i], roots[i], exs[i], $sformatf("known%0d", i));
  endtask

  task automatic test_busy_ignore();
    int pulses;
    pulses = 0;
    i_value  = 61'd256;
    i_status = 1'b1;
    tick();
    for (int n = 1; n <= LAT + 8; n++) begin
      if (n == 5 || n == 12) begin
        i_status = 1'b1;
        i_value  = 61'd6561;
      end else begin
        i_status = 1'b0;
      end
      tick();
      if (o_status === 1'b1) begin
        pulses++;
        checks++;
        if (n != LAT || o_value !== 8'd2 || o_exact !== 1'b1) begin
          errors++;
          $display("FAIL busy_result cycle=%0d value=%0d exact=%b want cycle=%0d value=2 exact=1",
                   n, o_value, o_exact, LAT);
        end
      end
      if (n == LAT + 1) begin
        checks++;
        if (o_ready !== 1'b1) begin
          errors++;
          $display("FAIL busy_ready_return got=%b want=1", o_ready);
        end
      end
    end
    i_status = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL busy_pulses got=%0d want=1", pulses);
    end
    do_req(61'd6561, 8'd3, 1'b1, "after_busy");
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    i_value  = 61'd390625;
    i_status = 1'b1;
    tick();
    i_status = 1'b0;
    for (int n = 1; n < 10; n++) begin
      tick();
      if (o_status === 1'b1) pulses++;
    end
    i_reset_sync = 1'b1;
    tick();
    i_reset_sync = 1'b0;
    checks++;
    if (o_value !== '0 || o_exact !== 1'b0 || o_ready !== 1'b1 || o_status !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state value=%0d exact=%b ready=%b status=%b want 0/0/1/0",
               o_value, o_exact, o_ready, o_status);
    end
    for (int n = 0; n < LAT + 4; n++) begin
      tick();
      if (o_status === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midreset_pulses got=%0d want=0", pulses);
    end
    do_req(61'd390625, 8'd5, 1'b1, "after_reset");
  endtask

  task automatic test_random_sweep();
    logic [IN_W-1:0] v;
    longint unsigned p;
    int unsigned r;
    for (int i = 0; i < 500; i++) begin
      v = rand_value();
      r = ref_root(64'(v));
      do_req(v, ROOT_W'(r), pow8(r) == 64'(v), "rand");
    end
    for (int n = 1; n <= 197; n++) begin
      p = pow8(n);
      r = ref_root(p);
      do_req(IN_W'(p), ROOT_W'(r), pow8(r) == p, "pow");
      r = ref_root(p - 1);
      do_req(IN_W'(p - 1), ROOT_W'(r), pow8(r) == p - 1, "pow_m1");
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    i_reset_sync = 1'b1;
    i_status = 1'b0;
    i_value = '0;
    test_reset();
    test_known();
    test_busy_ignore();
    test_reset_mid();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
